lsu_mem_stage: RTL and testbench

- Load/store unit sitting directly downstream of the decode controller.
- Consumes the decoded memory-op flags (mem, load, store, byte) plus the effective address and store data from execute.
- Drives a valid/yumi data-memory request port, waits for load responses, aligns and zero-extends byte loads, and returns a writeback result.
- Holds the pipeline via stall_o while an access is outstanding.

---
 rtl/lsu_mem_stage_pkg.sv | 22 ++
 rtl/lsu_mem_stage_byte_lane.sv | 24 ++
 rtl/lsu_mem_stage.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared types and constants for the load/store memory stage.
// The request layout assumes the default 32-bit address and a 4 x 8-bit data word.
package lsu_mem_stage_pkg;
  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;
  localparam int NUM_LANES  = 4;
  localparam int LANE_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic                  we;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
    logic [NUM_LANES-1:0]  mask;
  } lsu_req_s;
endpackage

// File: rtl/lsu_mem_stage_byte_lane.sv
// One little-endian byte lane: write enable, store byte steering and load byte pick.
module lsu_byte_lane
  import lsu_mem_stage_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [1:0]        lane_i,
  input  logic              byte_op_i,
  input  logic              store_i,
  input  logic [LANE_W-1:0] sbyte0_i,
  input  logic [LANE_W-1:0] sbyte_own_i,
  input  logic [LANE_W-1:0] rbyte_own_i,
  output logic              mask_o,
  output logic [LANE_W-1:0] wdata_o,
  output logic [LANE_W-1:0] rbyte_o
);
  logic sel;

  assign sel     = (lane_i == 2'(LANE));
  assign mask_o  = store_i & (~byte_op_i | sel);
  // Byte stores replicate the low byte so any lane can be written.
  assign wdata_o = byte_op_i ? sbyte0_i : sbyte_own_i;
  assign rbyte_o = sel ? rbyte_own_i : '0;
endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one outstanding valid/yumi memory access, byte-lane alignment,
// load writeback pulse and upstream stall.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              is_mem_op_i,
  input  logic              is_load_op_i,
  input  logic              is_store_op_i,
  input  logic              is_byte_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [RD_W-1:0]   rd_i,
  output logic              ready_o,
  output logic              stall_o,
  output logic              mem_req_valid_o,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  output logic [3:0]        mem_req_mask_o,
  input  logic              mem_req_yumi_i,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_resp_data_i,
  output logic              wb_valid_o,
  output logic [RD_W-1:0]   wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              misaligned_o
);
  lsu_state_e        state_q, state_d;
  logic              load_q, store_q, byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sdata_q, wb_data_q;
  logic [RD_W-1:0]   rd_q;

  logic accept, misaligned;
  logic [NUM_LANES-1:0]             lane_mask;
  logic [NUM_LANES-1:0][LANE_W-1:0] lane_wdata, lane_rbyte;
  logic [LANE_W-1:0]                ld_byte;
  logic [DATA_W-1:0]                ld_ext;
  lsu_req_s                         req;

  assign accept     = (state_q == IDLE) & valid_i & is_mem_op_i;
  assign misaligned = accept & ~is_byte_op_i & (addr_i[1:0] != 2'b00);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_byte_lane #(.LANE(g)) u_lane (
      .lane_i      (addr_q[1:0]),
      .byte_op_i   (byte_q),
      .store_i     (store_q),
      .sbyte0_i    (sdata_q[LANE_W-1:0]),
      .sbyte_own_i (sdata_q[g*LANE_W +: LANE_W]),
      .rbyte_own_i (mem_resp_data_i[g*LANE_W +: LANE_W]),
      .mask_o      (lane_mask[g]),
      .wdata_o     (lane_wdata[g]),
      .rbyte_o     (lane_rbyte[g])
    );
  end

  // Only the selected lane contributes a non-zero byte, so OR collapses them.
  always_comb begin
    ld_byte = '0;
    for (int i = 0; i < NUM_LANES; i++) ld_byte = ld_byte | lane_rbyte[i];
  end

  assign ld_ext = byte_q ? {{(DATA_W-LANE_W){1'b0}}, ld_byte} : mem_resp_data_i;

  always_comb begin
    req       = '0;
    req.we    = store_q;
    req.addr  = {addr_q[ADDR_W-1:2], 2'b00};
    req.wdata = lane_wdata;
    req.mask  = lane_mask;
  end

  assign mem_req_we_o    = req.we;
  assign mem_req_addr_o  = req.addr;
  assign mem_req_wdata_o = req.wdata;
  assign mem_req_mask_o  = req.mask;

  always_comb begin
    state_d         = state_q;
    ready_o         = 1'b0;
    stall_o         = 1'b0;
    mem_req_valid_o = 1'b0;
    wb_valid_o      = 1'b0;
    misaligned_o    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o      = 1'b1;
        misaligned_o = misaligned;
        if (accept && !misaligned) begin
          stall_o = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_o         = 1'b1;
        mem_req_valid_o = 1'b1;
        if (mem_req_yumi_i) state_d = load_q ? RESP : DONE;
      end
      RESP: begin
        stall_o = 1'b1;
        if (mem_resp_valid_i) state_d = DONE;
      end
      DONE: begin
        wb_valid_o = load_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      byte_q    <= 1'b0;
      addr_q    <= '0;
      sdata_q   <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        load_q  <= is_load_op_i;
        store_q <= is_store_op_i;
        byte_q  <= is_byte_op_i;
        addr_q  <= addr_i;
        sdata_q <= store_data_i;
        rd_q    <= rd_i;
      end
      if (state_q == RESP && mem_resp_valid_i) wb_data_q <= ld_ext;
    end
  end

  assign wb_rd_o   = rd_q;
  assign wb_data_o = wb_data_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: inputs change on the falling edge, outputs are
// checked 1 ns later against hand-computed values.
module tb_lsu_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, is_mem_op_i, is_load_op_i, is_store_op_i, is_byte_op_i;
  logic [31:0] addr_i, store_data_i;
  logic [4:0]  rd_i;
  logic        ready_o, stall_o, mem_req_valid_o, mem_req_we_o;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o;
  logic [3:0]  mem_req_mask_o;
  logic        mem_req_yumi_i, mem_resp_valid_i;
  logic [31:0] mem_resp_data_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  int req_base;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .reset(reset),
    .valid_i(valid_i), .is_mem_op_i(is_mem_op_i), .is_load_op_i(is_load_op_i),
    .is_store_op_i(is_store_op_i), .is_byte_op_i(is_byte_op_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .rd_i(rd_i),
    .ready_o(ready_o), .stall_o(stall_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
    .mem_req_mask_o(mem_req_mask_o), .mem_req_yumi_i(mem_req_yumi_i),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misaligned_o(misaligned_o)
  );

  always @(posedge clk)
    if (!reset && mem_req_valid_o && mem_req_yumi_i) req_cnt <= req_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    valid_i = 0; is_mem_op_i = 0; is_load_op_i = 0; is_store_op_i = 0; is_byte_op_i = 0;
    addr_i = '0; store_data_i = '0; rd_i = '0;
    mem_req_yumi_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = '0;
  endtask

  task automatic op(input logic ld, input logic st, input logic by,
                    input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    valid_i = 1; is_mem_op_i = 1; is_load_op_i = ld; is_store_op_i = st; is_byte_op_i = by;
    addr_i = a; store_data_i = d; rd_i = rd;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle_in();
    reset = 1;
    #12;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_reqv", 32'(mem_req_valid_o), 32'd0);
    chk("rst_wbv", 32'(wb_valid_o), 32'd0);
    chk("rst_wbdata", wb_data_o, 32'd0);
    step(); reset = 0;

    // LW 0x104 rd7, yumi at once, response next cycle
    step(); op(1, 0, 0, 32'h104, 32'h0, 5'd7); #1;
    chk("lw_c0_stall", 32'(stall_o), 32'd1);
    chk("lw_c0_reqv", 32'(mem_req_valid_o), 32'd0);
    step(); idle_in(); mem_req_yumi_i = 1; #1;
    chk("lw_c1_reqv", 32'(mem_req_valid_o), 32'd1);
    chk("lw_c1_addr", mem_req_addr_o, 32'h104);
    chk("lw_c1_we", 32'(mem_req_we_o), 32'd0);
    chk("lw_c1_mask", 32'(mem_req_mask_o), 32'd0);
    chk("lw_c1_stall", 32'(stall_o), 32'd1);
    step(); idle_in(); mem_resp_valid_i = 1; mem_resp_data_i = 32'hDEADBEEF; #1;
    chk("lw_c2_stall", 32'(stall_o), 32'd1);
    chk("lw_c2_reqv", 32'(mem_req_valid_o), 32'd0);
    chk("lw_c2_wbv", 32'(wb_valid_o), 32'd0);
    step(); idle_in(); #1;
    chk("lw_c3_wbv", 32'(wb_valid_o), 32'd1);
    chk("lw_c3_rd", 32'(wb_rd_o), 32'd7);
    chk("lw_c3_data", wb_data_o, 32'hDEADBEEF);
    chk("lw_c3_stall", 32'(stall_o), 32'd0);
    chk("lw_c3_ready", 32'(ready_o), 32'd0);
    step(); #1;
    chk("lw_c4_wbv", 32'(wb_valid_o), 32'd0);
    chk("lw_c4_ready", 32'(ready_o), 32'd1);

    // LBU 0x203: lane 3 of 0x11223344 is 0x11
    step(); op(1, 0, 1, 32'h203, 32'h0, 5'd4);
    step(); idle_in(); mem_req_yumi_i = 1; #1;
    chk("lbu_addr", mem_req_addr_o, 32'h200);
    chk("lbu_mask", 32'(mem_req_mask_o), 32'd0);
    step(); idle_in(); mem_resp_valid_i = 1; mem_resp_data_i = 32'h11223344;
    step(); idle_in(); #1;
    chk("lbu_wbv", 32'(wb_valid_o), 32'd1);
    chk("lbu_data", wb_data_o, 32'h00000011);
    chk("lbu_rd", 32'(wb_rd_o), 32'd4);

    // SB 0x302 data 0xAB, yumi withheld three cycles
    step(); op(0, 1, 1, 32'h302, 32'h000000AB, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(); idle_in(); #1;
      chk("sb_hold_v", 32'(mem_req_valid_o), 32'd1);
      chk("sb_hold_addr", mem_req_addr_o, 32'h300);
      chk("sb_hold_mask", 32'(mem_req_mask_o), 32'b0100);
      chk("sb_hold_wdata", mem_req_wdata_o, 32'hABABABAB);
      chk("sb_hold_we", 32'(mem_req_we_o), 32'd1);
    end
    step(); idle_in(); mem_req_yumi_i = 1; #1;
    chk("sb_yumi_v", 32'(mem_req_valid_o), 32'd1);
    chk("sb_yumi_mask", 32'(mem_req_mask_o), 32'b0100);
    step(); idle_in(); #1;
    chk("sb_done_wbv", 32'(wb_valid_o), 32'd0);
    chk("sb_done_stall", 32'(stall_o), 32'd0);
    chk("sb_done_reqv", 32'(mem_req_valid_o), 32'd0);
    step(); #1;
    chk("sb_idle_ready", 32'(ready_o), 32'd1);
    chk("sb_idle_wbv", 32'(wb_valid_o), 32'd0);

    // SW 0x106 misaligned: flagged and dropped
    step(); op(0, 1, 0, 32'h106, 32'h55667788, 5'd0); #1;
    chk("mis_flag", 32'(misaligned_o), 32'd1);
    chk("mis_stall", 32'(stall_o), 32'd0);
    chk("mis_ready", 32'(ready_o), 32'd1);
    chk("mis_reqv", 32'(mem_req_valid_o), 32'd0);
    step(); idle_in(); #1;
    chk("mis_next_flag", 32'(misaligned_o), 32'd0);
    chk("mis_next_ready", 32'(ready_o), 32'd1);
    chk("mis_next_reqv", 32'(mem_req_valid_o), 32'd0);

    // LW reset while waiting in RESP, then a stray response
    step(); op(1, 0, 0, 32'h400, 32'h0, 5'd3);
    step(); idle_in(); mem_req_yumi_i = 1;
    step(); idle_in(); #1;
    chk("rr_resp_stall", 32'(stall_o), 32'd1);
    #2 reset = 1; #1;
    chk("rr_ready", 32'(ready_o), 32'd1);
    chk("rr_stall", 32'(stall_o), 32'd0);
    chk("rr_reqv", 32'(mem_req_valid_o), 32'd0);
    chk("rr_wbv", 32'(wb_valid_o), 32'd0);
    chk("rr_rd", 32'(wb_rd_o), 32'd0);
    chk("rr_addr", mem_req_addr_o, 32'd0);
    step(); reset = 0; mem_resp_valid_i = 1; mem_resp_data_i = 32'hBAADF00D; #1;
    chk("rr_stray_wbv", 32'(wb_valid_o), 32'd0);
    step(); idle_in(); #1;
    chk("rr_stray_wbv2", 32'(wb_valid_o), 32'd0);
    chk("rr_stray_data", wb_data_o, 32'd0);
    chk("rr_idle_ready", 32'(ready_o), 32'd1);

    // SW 0x500 then LW 0x504 presented back to back
    req_base = req_cnt;
    step(); op(0, 1, 0, 32'h500, 32'h12345678, 5'd0);
    step(); mem_req_yumi_i = 1; #1;
    chk("b2b_sw_wdata", mem_req_wdata_o, 32'h12345678);
    chk("b2b_sw_mask", 32'(mem_req_mask_o), 32'hF);
    chk("b2b_sw_ready", 32'(ready_o), 32'd0);
    step(); mem_req_yumi_i = 0; op(1, 0, 0, 32'h504, 32'h0, 5'd9); #1;
    chk("b2b_done_ready", 32'(ready_o), 32'd0);
    chk("b2b_done_stall", 32'(stall_o), 32'd0);
    chk("b2b_done_reqv", 32'(mem_req_valid_o), 32'd0);
    step(); #1;
    chk("b2b_lw_accept_ready", 32'(ready_o), 32'd1);
    chk("b2b_lw_accept_stall", 32'(stall_o), 32'd1);
    step(); idle_in(); mem_req_yumi_i = 1; #1;
    chk("b2b_lw_addr", mem_req_addr_o, 32'h504);
    chk("b2b_lw_we", 32'(mem_req_we_o), 32'd0);
    step(); idle_in(); mem_resp_valid_i = 1; mem_resp_data_i = 32'hCAFEF00D;
    step(); idle_in(); #1;
    chk("b2b_lw_wbv", 32'(wb_valid_o), 32'd1);
    chk("b2b_lw_rd", 32'(wb_rd_o), 32'd9);
    chk("b2b_lw_data", wb_data_o, 32'hCAFEF00D);
    step(); step(); #1;
    chk("b2b_req_count", 32'(req_cnt - req_base), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
